// File: rtl/led_sequence_monitor.sv
// Passive monitor for a 16-bit thermometer LED bus: decodes the lit level and tracks
// rise/fall reversals, sequence completion, and illegal bus shapes or multi-level jumps.
module led_sequence_monitor #(
  parameter int IDLE_HOLD = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      LED,
  input  logic             err_clr,
  output logic [4:0]       level,
  output logic             dir_up,
  output logic             turn,
  output logic [4:0]       turn_level,
  output logic [CNT_W-1:0] turn_cnt,
  output logic [4:0]       max_level,
  output logic             seq_done,
  output logic             err_shape,
  output logic             err_step
);

  localparam int ZW = $clog2(IDLE_HOLD + 1);

  typedef enum logic [1:0] {IDLE, RISE, FALL, ZERO} state_t;

  state_t          state;
  logic [ZW-1:0]   zcnt;

  logic [16:0]     led_x;
  logic            valid;
  logic [4:0]      cur;
  logic            up, dn, big;
  logic [CNT_W-1:0] cnt_inc;

  // A thermometer code plus one is a power of two, so it shares no set bit with itself.
  always_comb begin
    led_x   = {1'b0, LED};
    valid   = ((led_x + 17'd1) & led_x) == 17'd0;
    cur     = 5'($countones(LED));
    up      = cur > level;
    dn      = cur < level;
    big     = up ? ((cur - level) > 5'd1) : (dn ? ((level - cur) > 5'd1) : 1'b0);
    cnt_inc = (&turn_cnt) ? turn_cnt : turn_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      zcnt       <= '0;
      level      <= '0;
      dir_up     <= 1'b0;
      turn       <= 1'b0;
      turn_level <= '0;
      turn_cnt   <= '0;
      max_level  <= '0;
      seq_done   <= 1'b0;
      err_shape  <= 1'b0;
      err_step   <= 1'b0;
    end else begin
      turn      <= 1'b0;
      seq_done  <= 1'b0;
      // A fresh error in the same cycle as err_clr keeps the flag set.
      err_shape <= (err_shape & ~err_clr) | ~valid;
      err_step  <= (err_step & ~err_clr) | (valid & big);
      if (valid) begin
        level <= cur;
        unique case (state)
          IDLE: begin
            if (cur != 5'd0) begin
              state     <= RISE;
              dir_up    <= 1'b1;
              turn_cnt  <= '0;
              max_level <= cur;
              zcnt      <= '0;
            end
          end
          RISE: begin
            if (up) begin
              if (cur > max_level) max_level <= cur;
            end else if (dn) begin
              turn       <= 1'b1;
              turn_level <= level;
              turn_cnt   <= cnt_inc;
              dir_up     <= 1'b0;
              // Dropping straight to zero lands in the zero-hold phase.
              if (cur == 5'd0) begin
                state <= ZERO;
                zcnt  <= ZW'(1);
              end else begin
                state <= FALL;
              end
            end
          end
          FALL: begin
            if (up) begin
              state      <= RISE;
              dir_up     <= 1'b1;
              turn       <= 1'b1;
              turn_level <= level;
              turn_cnt   <= cnt_inc;
              if (cur > max_level) max_level <= cur;
            end else if (cur == 5'd0) begin
              state <= ZERO;
              zcnt  <= ZW'(1);
            end
          end
          ZERO: begin
            if (up) begin
              state      <= RISE;
              dir_up     <= 1'b1;
              turn       <= 1'b1;
              turn_level <= 5'd0;
              turn_cnt   <= cnt_inc;
              zcnt       <= '0;
              if (cur > max_level) max_level <= cur;
            end else if (zcnt == ZW'(IDLE_HOLD - 1)) begin
              state    <= IDLE;
              seq_done <= 1'b1;
              zcnt     <= '0;
            end else begin
              zcnt <= zcnt + ZW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Bench for led_sequence_monitor: directed flasher scenarios plus a random walk,
// every cycle compared against a level/direction/zero-run reference model.
module tb_led_sequence_monitor;
  localparam int IH  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err_clr = 1'b0;
  logic [15:0]   led = '0;
  logic [4:0]    level, turn_level, max_level;
  logic          dir_up, turn, seq_done, err_shape, err_step;
  logic [CW-1:0] turn_cnt;

  always #5 clk = ~clk;

  led_sequence_monitor #(.IDLE_HOLD(IH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .LED(led), .err_clr(err_clr),
    .level(level), .dir_up(dir_up), .turn(turn), .turn_level(turn_level),
    .turn_cnt(turn_cnt), .max_level(max_level), .seq_done(seq_done),
    .err_shape(err_shape), .err_step(err_step)
  );

  int n_cmp = 0, n_bad = 0;

  // reference model: sequence activity, last direction, consecutive zero samples
  int m_level, m_tlvl, m_tcnt, m_max, m_zrun;
  bit m_active, m_up, m_turn, m_done, m_es, m_ep;

  int turn_log[$];
  int n_done;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int k);
    int v;
    v = (1 << k) - 1;
    return v[15:0];
  endfunction

  task automatic model(input logic [15:0] l, input bit clr, input bit rs);
    int c, d;
    bit ok;
    if (!rs) begin
      m_level = 0; m_tlvl = 0; m_tcnt = 0; m_max = 0; m_zrun = 0;
      m_active = 0; m_up = 0; m_turn = 0; m_done = 0; m_es = 0; m_ep = 0;
      return;
    end
    m_turn = 0; m_done = 0;
    c  = $countones(l);
    ok = (int'(l) == (1 << c) - 1);
    d  = c - m_level;
    m_es = (m_es && !clr) || !ok;
    m_ep = (m_ep && !clr) || (ok && (d > 1 || d < -1));
    if (!ok) return;
    if (!m_active) begin
      if (c > 0) begin
        m_active = 1; m_up = 1; m_tcnt = 0; m_max = c; m_zrun = 0;
      end
    end else if (d > 0) begin
      if (!m_up) begin
        m_turn = 1; m_tlvl = m_level; m_tcnt = (m_tcnt < SAT) ? m_tcnt + 1 : SAT;
      end
      m_up = 1; m_zrun = 0;
      if (c > m_max) m_max = c;
    end else if (d < 0) begin
      if (m_up) begin
        m_turn = 1; m_tlvl = m_level; m_tcnt = (m_tcnt < SAT) ? m_tcnt + 1 : SAT;
      end
      m_up = 0;
      if (c == 0) m_zrun = 1;
    end else if (c == 0) begin
      m_zrun++;
      if (m_zrun == IH) begin
        m_done = 1; m_active = 0; m_zrun = 0;
      end
    end
    m_level = c;
  endtask

  task automatic step_raw(input logic [15:0] l, input bit clr, input bit rs);
    led = l; err_clr = clr; rst_n = rs;
    @(posedge clk); #1;
    model(l, clr, rs);
    chk("level", level, m_level);
    chk("dir_up", dir_up, int'(m_active && m_up));
    chk("turn", turn, int'(m_turn));
    chk("turn_level", turn_level, m_tlvl);
    chk("turn_cnt", turn_cnt, m_tcnt);
    chk("max_level", max_level, m_max);
    chk("seq_done", seq_done, int'(m_done));
    chk("err_shape", err_shape, int'(m_es));
    chk("err_step", err_step, int'(m_ep));
    if (turn === 1'b1) turn_log.push_back(int'(turn_level));
    if (seq_done === 1'b1) n_done++;
    err_clr = 1'b0;
  endtask

  task automatic step(input int k);
    step_raw(therm(k), 1'b0, 1'b1);
  endtask

  task automatic ramp(input int a, input int b);
    if (a < b) for (int k = a + 1; k <= b; k++) step(k);
    else       for (int k = a - 1; k >= b; k--) step(k);
  endtask

  task automatic do_reset();
    step_raw(led, 1'b0, 1'b0);
    step_raw(led, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_turns[5] = '{16, 5, 10, 0, 5};
    int nd, lv, r;
    logic [15:0] junk;

    do_reset();
    chk("rst_level", level, 0);
    chk("rst_done", seq_done, 0);

    // standard pass
    turn_log.delete(); n_done = 0;
    step(0); step(0);
    chk("idle_quiet", dir_up, 0);
    ramp(0, 16); ramp(16, 5); ramp(5, 10); ramp(10, 0); ramp(0, 5); ramp(5, 0);
    repeat (4) step(0);
    chk("std_nturns", turn_log.size(), 5);
    for (int i = 0; i < 5 && i < turn_log.size(); i++) chk("std_turn_lvl", turn_log[i], exp_turns[i]);
    chk("std_ndone", n_done, 1);
    chk("std_tcnt", turn_cnt, 5);
    chk("std_max", max_level, 16);
    chk("std_errs", {err_shape, err_step}, 0);

    // zero hold boundary
    ramp(0, 3); ramp(3, 0);
    nd = n_done;
    step(0); step(0); step(1);
    chk("zb_turn", turn, 1);
    chk("zb_turn_lvl", turn_level, 0);
    chk("zb_nodone", n_done, nd);
    step(0); step(0); step(0);
    chk("zb_before", seq_done, 0);
    step(0);
    chk("zb_done", seq_done, 1);

    // shape error mid-rise
    do_reset();
    ramp(0, 3);
    step_raw(16'h0005, 1'b0, 1'b1);
    chk("sh_flag", err_shape, 1);
    chk("sh_hold", level, 3);
    chk("sh_dir", dir_up, 1);
    step(4);
    chk("sh_next", level, 4);
    chk("sh_noturn", turn, 0);
    step_raw(therm(4), 1'b1, 1'b1);
    chk("sh_clr", err_shape, 0);
    step_raw(16'h0009, 1'b1, 1'b1);
    chk("sh_clr_wins", err_shape, 1);

    // step error
    do_reset();
    ramp(0, 2);
    step(6);
    chk("st_flag", err_step, 1);
    chk("st_level", level, 6);
    chk("st_dir", dir_up, 1);
    step(1);
    chk("st_turn", turn, 1);
    chk("st_tlvl", turn_level, 6);
    chk("st_fall", dir_up, 0);

    // reset mid-sequence in FALL
    do_reset();
    ramp(0, 12); ramp(12, 9);
    nd = n_done;
    step_raw(therm(9), 1'b0, 1'b0);
    chk("mr_level", level, 0);
    chk("mr_nodone", n_done, nd);
    step(1);
    chk("mr_rise", dir_up, 1);
    chk("mr_tcnt", turn_cnt, 0);

    // turn counter saturation
    repeat (12) begin step(2); step(1); end
    chk("sat_tcnt", turn_cnt, SAT);

    // random walk
    lv = 1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        step_raw(therm(lv), 1'b0, 1'b0); lv = 0;
      end else if (r < 6) begin
        junk = (16'($urandom) | 16'h0005) & ~16'h0002;
        step_raw(junk, ($urandom_range(0, 9) == 0), 1'b1);
      end else begin
        if (r < 38) lv = (lv < 16) ? lv + 1 : lv;
        else if (r < 72) lv = (lv > 0) ? lv - 1 : lv;
        else if (r < 77) lv = $urandom_range(0, 16);
        else if (r < 85) lv = lv;
        else lv = 0;
        step_raw(therm(lv), ($urandom_range(0, 19) == 0), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
